// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Drain stage for an 8-deep x 8-bit synchronous FIFO. Pops one byte at a time
// and sends it on tx as an asynchronous serial frame:
//   start bit (0), 8 data bits LSB first, optional parity bit, 1 or 2 stop
//   bits (1).
// The FIFO is shared with an upstream writer, and a write inside the FIFO
// wins over a read in the same cycle. A read request that collides with a
// write is therefore held until it is actually accepted.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (2..65535)
//   STOP_BITS     number of stop bits (1 or 2)
//   PARITY_EN     1 = parity bit follows data bit 7
//   PARITY_ODD    0 = even parity, 1 = odd parity (only used with PARITY_EN)
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous, active-low reset
//   en          in   1 = new frames may start; a frame in flight always ends
//   fifo_empty  in   FIFO empty flag
//   fifo_we     in   FIFO write enable (the same signal that drives the FIFO)
//   fifo_dout   in   FIFO read data, valid the cycle after an accepted read
//   fifo_re     out  FIFO read enable (registered)
//   tx          out  serial line (registered, idles high)
//   busy        out  1 whenever the FSM is not idle
//   frame_done  out  1-cycle pulse in the last cycle of the final stop bit
//   bytes_sent  out  frames completed since reset, wraps 0xFFFF -> 0
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        fifo_empty,
  input  logic        fifo_we,
  input  logic [7:0]  fifo_dout,
  output logic        fifo_re,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] bytes_sent
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic        USE_PAR   = (PARITY_EN != 0);
  localparam logic        PAR_ODD   = (PARITY_ODD != 0);

  state_t      state, state_nxt;
  logic [15:0] baud, baud_nxt;       // cycle within the current bit
  logic [2:0]  bit_cnt, bit_nxt;     // data bit index, reused as stop bit index
  logic [7:0]  shift, shift_nxt;     // bit 0 is the data bit on the line
  logic        parity_bit, parity_nxt;
  logic        tx_nxt;
  logic        re_nxt;
  logic [15:0] bytes_nxt;
  logic        baud_done;

  assign baud_done = (baud == BAUD_LAST);
  assign busy      = (state != IDLE);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: synchronous reset: rst is sampled only on the clock edge, so it sits
  // inside the clocked branch and is not in the sensitivity list. Every
  // register is reset, including the shift register, so a frame aborted by
  // reset leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      baud       <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      fifo_re    <= 1'b0;
      bytes_sent <= '0;
    end else begin
      state      <= state_nxt;
      baud       <= baud_nxt;
      bit_cnt    <= bit_nxt;
      shift      <= shift_nxt;
      parity_bit <= parity_nxt;
      tx         <= tx_nxt;
      fifo_re    <= re_nxt;
      bytes_sent <= bytes_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-value logic
  // tx is registered, so the value for the first cycle of a bit is computed
  // here on the edge that enters that bit.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in this block gets its default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    baud_nxt   = baud + 16'd1;
    bit_nxt    = bit_cnt;
    shift_nxt  = shift;
    parity_nxt = parity_bit;
    tx_nxt     = tx;
    re_nxt     = fifo_re;
    bytes_nxt  = bytes_sent;
    frame_done = 1'b0;

    unique case (state)
      IDLE: begin
        baud_nxt = '0;
        tx_nxt   = 1'b1;
        re_nxt   = 1'b0;
        if (en && !fifo_empty) begin
          re_nxt    = 1'b1;
          state_nxt = REQ;
        end
      end

      // The FIFO samples fifo_re on this edge. A simultaneous write makes the
      // FIFO drop the read, so the request is held until a write-free edge.
      // en is deliberately ignored: a pending read is never cancelled.
      REQ: begin
        baud_nxt = '0;
        if (!fifo_we) begin
          re_nxt    = 1'b0;
          state_nxt = LOAD;
        end
      end

      // fifo_dout is valid now (one cycle after the accepted read).
      LOAD: begin
        baud_nxt   = '0;
        shift_nxt  = fifo_dout;
        parity_nxt = (^fifo_dout) ^ PAR_ODD;
        tx_nxt     = 1'b0;
        state_nxt  = START;
      end

      START: begin
        if (baud_done) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          tx_nxt    = shift[0];
          state_nxt = DATA;
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_nxt = '0;
          if (bit_cnt == 3'd7) begin
            bit_nxt = '0;
            if (USE_PAR) begin
              tx_nxt    = parity_bit;
              state_nxt = PARITY;
            end else begin
              tx_nxt    = 1'b1;
              state_nxt = STOP;
            end
          end else begin
            bit_nxt   = bit_cnt + 3'd1;
            shift_nxt = {1'b0, shift[7:1]};
            tx_nxt    = shift[1];
          end
        end
      end

      PARITY: begin
        if (baud_done) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          tx_nxt    = 1'b1;
          state_nxt = STOP;
        end
      end

      STOP: begin
        tx_nxt = 1'b1;
        if (baud_done) begin
          baud_nxt = '0;
          if (bit_cnt == STOP_LAST) begin
            frame_done = 1'b1;
            bytes_nxt  = bytes_sent + 16'd1;
            bit_nxt    = '0;
            state_nxt  = IDLE;
          end else begin
            bit_nxt = bit_cnt + 3'd1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        re_nxt    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Two transmitters with 4 clocks per bit, each fed by its own FIFO model
// (8 x 8, registered read data, write wins over read):
//   dut0: 1 stop bit, no parity
//   dut1: 2 stop bits, even parity
// Each scenario task drives stimulus and compares against hand-computed
// expected values. Frames are written as vectors whose bit i is the i-th bit
// on the line: {stop bit(s), [parity], data byte, start bit}.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] en  = 2'b00;
  logic [1:0] we  = 2'b00;
  logic [1:0] clr = 2'b00;
  logic [7:0] wdata [2] = '{8'h00, 8'h00};

  wire  [1:0]       fifo_re;
  wire  [1:0]       tx;
  wire  [1:0]       busy;
  wire  [1:0]       frame_done;
  wire  [1:0][15:0] bytes_sent;
  wire  [1:0]       empty;

  int passed = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // FIFO models plus bookkeeping on the read side
  // ---------------------------------------------------------------------------
  logic [7:0] mem  [2][8];
  logic [7:0] dout [2]   = '{8'h00, 8'h00};
  logic [2:0] wp   [2]   = '{3'd0, 3'd0};
  logic [2:0] rp   [2]   = '{3'd0, 3'd0};
  logic [3:0] cnt  [2]   = '{4'd0, 4'd0};
  int         pops    [2] = '{0, 0};
  int         re_hi   [2] = '{0, 0};
  int         re_rise [2] = '{0, 0};
  logic [1:0] re_prev = 2'b00;

  assign empty = {cnt[1] == 4'd0, cnt[0] == 4'd0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (clr[k]) begin
        wp[k]  <= 3'd0;
        rp[k]  <= 3'd0;
        cnt[k] <= 4'd0;
      end else if (we[k]) begin
        if (cnt[k] != 4'd8) begin
          mem[k][wp[k]] <= wdata[k];
          wp[k]         <= wp[k] + 3'd1;
          cnt[k]        <= cnt[k] + 4'd1;
        end
      end else if (fifo_re[k] && cnt[k] != 4'd0) begin
        dout[k] <= mem[k][rp[k]];
        rp[k]   <= rp[k] + 3'd1;
        cnt[k]  <= cnt[k] - 4'd1;
        pops[k] <= pops[k] + 1;
      end
      if (fifo_re[k]) re_hi[k] <= re_hi[k] + 1;
      if (fifo_re[k] && !re_prev[k]) re_rise[k] <= re_rise[k] + 1;
      re_prev[k] <= fifo_re[k];
    end
  end

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)
  ) dut0 (
    .clk(clk), .rst(rst), .en(en[0]), .fifo_empty(empty[0]), .fifo_we(we[0]),
    .fifo_dout(dout[0]), .fifo_re(fifo_re[0]), .tx(tx[0]), .busy(busy[0]),
    .frame_done(frame_done[0]), .bytes_sent(bytes_sent[0])
  );

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut1 (
    .clk(clk), .rst(rst), .en(en[1]), .fifo_empty(empty[1]), .fifo_we(we[1]),
    .fifo_dout(dout[1]), .fifo_re(fifo_re[1]), .tx(tx[1]), .busy(busy[1]),
    .frame_done(frame_done[1]), .bytes_sent(bytes_sent[1])
  );

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [7:0] d);
    wdata[k] = d;
    we[k]    = 1'b1;
    tick();
    we[k]    = 1'b0;
  endtask

  // Waits (bounded) for the first start-bit cycle; n = cycles waited.
  task automatic wait_start(input int k, output int n);
    n = 0;
    while (tx[k] !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    if (tx[k] !== 1'b0) begin
      checks++;
      $display("FAIL wait_start dut%0d: tx still %b after 60 cycles, want 0", k, tx[k]);
    end
  endtask

  // Called in the first start-bit cycle; returns in the cycle after the frame.
  // drop_at >= 0 clears en[k] at that cycle offset into the frame.
  task automatic expect_frame(input int k, input logic [11:0] frame, input int nbits,
                              input int drop_at, input string name);
    logic [11:0] bit_ok;
    int          done_cnt;
    int          done_at;
    bit_ok   = '1;
    done_cnt = 0;
    done_at  = -1;
    for (int i = 0; i < nbits * CPB; i++) begin
      if (i == drop_at) en[k] = 1'b0;
      if (tx[k] !== frame[i / CPB]) bit_ok[i / CPB] = 1'b0;
      if (frame_done[k] === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      tick();
    end
    for (int b = 0; b < nbits; b++) begin
      checks++;
      if (!bit_ok[b]) $display("FAIL %s line bit %0d: tx differs from %b in some cycle", name, b, frame[b]);
      else passed++;
    end
    checks++;
    if (done_cnt !== 1 || done_at !== nbits * CPB - 1)
      $display("FAIL %s frame_done: got %0d pulses first at %0d, want 1 at %0d", name, done_cnt, done_at, nbits * CPB - 1);
    else passed++;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    tick();
    wdata[0] = 8'h5A;
    wdata[1] = 8'h5A;
    we       = 2'b11;
    tick();
    we       = 2'b00;
    en       = 2'b11;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++; if (tx[k] !== 1'b1) $display("FAIL reset tx dut%0d: got %b want 1", k, tx[k]); else passed++;
        checks++; if (fifo_re[k] !== 1'b0) $display("FAIL reset fifo_re dut%0d: got %b want 0", k, fifo_re[k]); else passed++;
        checks++; if (busy[k] !== 1'b0) $display("FAIL reset busy dut%0d: got %b want 0", k, busy[k]); else passed++;
        checks++; if (bytes_sent[k] !== 16'd0) $display("FAIL reset bytes_sent dut%0d: got %0d want 0", k, bytes_sent[k]); else passed++;
      end
    end
    en  = 2'b00;
    rst = 1'b1;
    clr = 2'b11;
    tick();
    clr = 2'b00;
    checks++; if (busy !== 2'b00) $display("FAIL reset release busy: got %b want 00", busy); else passed++;
    checks++; if (empty !== 2'b11) $display("FAIL reset fifo flush: empty got %b want 11", empty); else passed++;
  endtask

  task automatic test_single_frame();
    int n;
    int p0, r0;
    p0 = pops[0];
    r0 = re_hi[0];
    en[0] = 1'b1;
    push(0, 8'hA5);
    wait_start(0, n);
    checks++; if (n !== 3) $display("FAIL single latency: got %0d cycles want 3", n); else passed++;
    expect_frame(0, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, -1, "single_A5");
    checks++; if (bytes_sent[0] !== 16'd1) $display("FAIL single bytes_sent: got %0d want 1", bytes_sent[0]); else passed++;
    checks++; if (busy[0] !== 1'b0 || tx[0] !== 1'b1) $display("FAIL single idle: busy=%b tx=%b want 0/1", busy[0], tx[0]); else passed++;
    checks++; if (pops[0] - p0 !== 1) $display("FAIL single pops: got %0d want 1", pops[0] - p0); else passed++;
    checks++; if (re_hi[0] - r0 !== 1) $display("FAIL single fifo_re cycles: got %0d want 1", re_hi[0] - r0); else passed++;
  endtask

  task automatic test_back_to_back();
    int n;
    int p0, r0;
    p0 = pops[0];
    r0 = re_rise[0];
    wdata[0] = 8'h01;
    we[0]    = 1'b1;
    tick();
    wdata[0] = 8'h02;
    tick();
    wdata[0] = 8'h03;
    tick();
    we[0]    = 1'b0;
    wait_start(0, n);
    expect_frame(0, {2'b00, 1'b1, 8'h01, 1'b0}, 10, -1, "b2b_01");
    wait_start(0, n);
    checks++; if (n !== 3) $display("FAIL b2b gap 1: got %0d high cycles want 3", n); else passed++;
    expect_frame(0, {2'b00, 1'b1, 8'h02, 1'b0}, 10, -1, "b2b_02");
    wait_start(0, n);
    checks++; if (n !== 3) $display("FAIL b2b gap 2: got %0d high cycles want 3", n); else passed++;
    expect_frame(0, {2'b00, 1'b1, 8'h03, 1'b0}, 10, -1, "b2b_03");
    checks++; if (bytes_sent[0] !== 16'd4) $display("FAIL b2b bytes_sent: got %0d want 4", bytes_sent[0]); else passed++;
    checks++; if (cnt[0] !== 4'd0) $display("FAIL b2b fifo level: got %0d want 0", cnt[0]); else passed++;
    checks++; if (pops[0] - p0 !== 3) $display("FAIL b2b pops: got %0d want 3", pops[0] - p0); else passed++;
    checks++; if (re_rise[0] - r0 !== 3) $display("FAIL b2b fifo_re pulses: got %0d want 3", re_rise[0] - r0); else passed++;
  endtask

  // Writes land while the read is pending; en also drops in REQ, so the two
  // written bytes stay queued for the next scenario.
  task automatic test_we_collision();
    int n;
    int p0, r0;
    p0 = pops[0];
    r0 = re_hi[0];
    push(0, 8'h3C);
    tick();
    checks++; if (fifo_re[0] !== 1'b1) $display("FAIL collision fifo_re in REQ: got %b want 1", fifo_re[0]); else passed++;
    en[0]    = 1'b0;
    wdata[0] = 8'hC3;
    we[0]    = 1'b1;
    tick();
    wdata[0] = 8'h99;
    tick();
    we[0]    = 1'b0;
    checks++; if (fifo_re[0] !== 1'b1) $display("FAIL collision fifo_re held: got %b want 1", fifo_re[0]); else passed++;
    wait_start(0, n);
    expect_frame(0, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, -1, "collision_3C");
    checks++; if (re_hi[0] - r0 !== 3) $display("FAIL collision fifo_re cycles: got %0d want 3", re_hi[0] - r0); else passed++;
    checks++; if (pops[0] - p0 !== 1) $display("FAIL collision pops: got %0d want 1", pops[0] - p0); else passed++;
    checks++; if (cnt[0] !== 4'd2) $display("FAIL collision fifo level: got %0d want 2", cnt[0]); else passed++;
    checks++; if (bytes_sent[0] !== 16'd5) $display("FAIL collision bytes_sent: got %0d want 5", bytes_sent[0]); else passed++;
    r0 = re_hi[0];
    for (int c = 0; c < 6; c++) tick();
    checks++; if (re_hi[0] - r0 !== 0) $display("FAIL collision en=0 read: got %0d fifo_re cycles want 0", re_hi[0] - r0); else passed++;
  endtask

  task automatic test_en_mid_frame();
    int n;
    int r0;
    int low_cnt;
    int busy_cnt;
    r0 = re_hi[0];
    en[0] = 1'b1;
    wait_start(0, n);
    checks++; if (n !== 3) $display("FAIL en_mid latency: got %0d want 3", n); else passed++;
    expect_frame(0, {2'b00, 1'b1, 8'hC3, 1'b0}, 10, 12, "en_mid_C3");
    low_cnt  = 0;
    busy_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (tx[0] !== 1'b1) low_cnt++;
      if (busy[0] !== 1'b0) busy_cnt++;
      tick();
    end
    checks++; if (low_cnt !== 0 || busy_cnt !== 0) $display("FAIL en_mid idle: tx-low cycles %0d busy cycles %0d want 0/0", low_cnt, busy_cnt); else passed++;
    checks++; if (re_hi[0] - r0 !== 1) $display("FAIL en_mid fifo_re cycles: got %0d want 1", re_hi[0] - r0); else passed++;
    checks++; if (cnt[0] !== 4'd1) $display("FAIL en_mid fifo level: got %0d want 1", cnt[0]); else passed++;
    checks++; if (bytes_sent[0] !== 16'd6) $display("FAIL en_mid bytes_sent: got %0d want 6", bytes_sent[0]); else passed++;
    en[0] = 1'b1;
    wait_start(0, n);
    checks++; if (n !== 3) $display("FAIL en_mid resume latency: got %0d want 3", n); else passed++;
    expect_frame(0, {2'b00, 1'b1, 8'h99, 1'b0}, 10, -1, "en_mid_99");
    checks++; if (bytes_sent[0] !== 16'd7) $display("FAIL en_mid final bytes_sent: got %0d want 7", bytes_sent[0]); else passed++;
    checks++; if (cnt[0] !== 4'd0) $display("FAIL en_mid final fifo level: got %0d want 0", cnt[0]); else passed++;
  endtask

  // 0x07 has three ones, so even parity sends 1.
  task automatic test_parity_two_stop();
    int n;
    en[1] = 1'b1;
    push(1, 8'h07);
    wait_start(1, n);
    checks++; if (n !== 3) $display("FAIL parity latency: got %0d want 3", n); else passed++;
    expect_frame(1, {2'b11, 1'b1, 8'h07, 1'b0}, 12, -1, "parity_07");
    checks++; if (bytes_sent[1] !== 16'd1) $display("FAIL parity bytes_sent: got %0d want 1", bytes_sent[1]); else passed++;
    checks++; if (busy[1] !== 1'b0) $display("FAIL parity busy after frame: got %b want 0", busy[1]); else passed++;
  endtask

  // Byte 0x00 keeps tx low through data, so the reset recovery is visible.
  task automatic test_reset_mid_frame();
    int n;
    push(1, 8'h00);
    wait_start(1, n);
    for (int c = 0; c < 6; c++) tick();
    checks++; if (tx[1] !== 1'b0 || busy[1] !== 1'b1) $display("FAIL rst_mid precondition: tx=%b busy=%b want 0/1", tx[1], busy[1]); else passed++;
    rst = 1'b0;
    tick();
    checks++; if (tx[1] !== 1'b1) $display("FAIL rst_mid tx: got %b want 1", tx[1]); else passed++;
    checks++; if (busy[1] !== 1'b0) $display("FAIL rst_mid busy: got %b want 0", busy[1]); else passed++;
    checks++; if (frame_done[1] !== 1'b0) $display("FAIL rst_mid frame_done: got %b want 0", frame_done[1]); else passed++;
    checks++; if (bytes_sent[1] !== 16'd0) $display("FAIL rst_mid bytes_sent dut1: got %0d want 0", bytes_sent[1]); else passed++;
    checks++; if (bytes_sent[0] !== 16'd0) $display("FAIL rst_mid bytes_sent dut0: got %0d want 0", bytes_sent[0]); else passed++;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 2'b00 || tx !== 2'b11) $display("FAIL rst_mid after release: busy=%b tx=%b want 00/11", busy, tx); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_we_collision();
    test_en_mid_frame();
    test_parity_two_stop();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule
